pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Two-entry pipeline stage register with a valid/ready handshake on both sides; this is the consumer-facing counterpart to the plain write-enable stage register.
- Upstream writes a word when it is accepted; downstream reads the word and pops it by asserting out_ready.
- The skid entry absorbs one in-flight word when downstream stalls. This gives full throughput with no combinational ready path from out_ready to in_ready.
- It sits between processor pipeline stages, for example between IF and ID, and supports stall and flush.

Parameters:
- N, 32, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  input  1  discards all held entries at the next edge.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N  upstream payload.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream consumes the word this cycle.
- out_data  output  N  head-of-stage payload.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Storage: main register (head) and skid register.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid, occupancy 1.
  - TWO: main and skid valid, occupancy 2.
- Decoded outputs, combinational from registered state only:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - out_data = main.
  - occupancy as listed above.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_ready never combinationally affects in_ready.
- Reset (rst==0 at an edge):
  - state <= EMPTY; main <= 0; skid <= 0.
  - After that edge: out_valid=0, in_ready=1, occupancy=0, out_data=0.
  - Reset overrides flush and all handshakes.
  - Reset asserted mid-transfer drops all held words; no partial state remains.
- Flush (rst==1, flush==1):
  - state <= EMPTY; main and skid hold their values.
  - push and pop in that cycle have no effect on state, and the input word is discarded.
- Transitions (rst==1, flush==0):
  - EMPTY: push -> ONE, main <= in_data. Otherwise stay.
  - ONE:
    - push & pop -> ONE, main <= in_data.
    - push & !pop -> TWO, skid <= in_data.
    - !push & pop -> EMPTY.
    - neither -> stay.
  - TWO:
    - in_ready=0, so there is no push.
    - pop -> ONE, main <= skid.
    - !pop -> stay.
- Latency: a word pushed at edge k is visible on out_data after edge k (one cycle) when the stage was EMPTY, or when it was ONE and popping.
- Throughput: one word per cycle with out_ready held high.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change. The only exceptions are flush and reset.
- Ordering: words leave strictly in acceptance order; none are duplicated or lost, except on flush or reset.
- in_data is don't-care when in_valid=0.
- in_valid may drop without being accepted; no upstream hold rule is enforced.

Test Plan:
- Reset then stream: hold rst=0 for 2 cycles, then release. Push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 one cycle after each push. in_ready stays 1 and occupancy stays 1.
- Stall fill: out_ready=0, push 0xA0 then 0xB0 -> occupancy 2, in_ready=0, out_data=0xA0. A third in_valid with 0xC0 is not accepted.
- Drain after stall: from the stall-fill state, raise out_ready for 2 cycles -> out_data 0xA0, then 0xB0, then out_valid=0 and occupancy 0. in_ready returns to 1 after the first pop.
- Simultaneous push/pop in ONE: main=0x5, push 0x6 with out_ready=1 -> next cycle out_data=0x6 and occupancy stays 1.
- Flush: occupancy 2 (0x1, 0x2), flush=1 together with in_valid=1 carrying 0x3 -> next cycle out_valid=0, occupancy 0. 0x3 never appears on out_data.
- Reset mid-operation: occupancy 2, assert rst=0 for one edge with flush=0 -> out_valid=0, out_data=0, in_ready=1. Push 0x7 after release -> out_data=0x7.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline stage (main + skid). in_ready and out_valid
// decode from registered state only, so out_ready never reaches in_ready.
module pipe_skid_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    // Encoding equals the number of held entries, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] main_q, main_nxt;
    logic [N-1:0] skid_q, skid_nxt;
    logic         push, pop;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_nxt = in_data;
                    end else if (push) begin
                        state_nxt = TWO;
                        skid_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // The data registers are cleared too, so out_data reads 0 after reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

endmodule
